fpu_addsub_seq: RTL and testbench
=================================

// Module: fpu_addsub_seq
// PURPOSE
//  Sequential, parametrised minifloat add/subtract unit; successor to the single-cycle 9-bit FPU.
//  Format {sign, EXP_W exponent, FRAC_W fraction}, hidden 1, bias BIAS; exp==0 encodes zero (frac ignored).
//  Adds round-to-nearest-even (guard/round/sticky), overflow/underflow flags and valid/ready handshakes.
//  Bit-serial align/normalise shifters trade latency for area; sits between operand regs and writeback.
// PARAMETERS
//  EXP_W   4                  exponent width
//  FRAC_W  4                  stored fraction width
//  BIAS    2**(EXP_W-1)-1     exponent bias
//  W = 1+EXP_W+FRAC_W         derived localparam, operand/result width
// PORTS
//  CLK        in   1  clock, all state on rising edge
//  RST        in   1  synchronous, active-high reset
//  IN_VALID   in   1  operands/ADDSUB valid
//  IN_READY   out  1  unit idle, operands accepted on IN_VALID&&IN_READY edge
//  A, B       in   W  operands
//  ADDSUB     in   1  0: A+B, 1: A-B
//  OUT_VALID  out  1  result valid
//  OUT_READY  in   1  consumer takes result on OUT_VALID&&OUT_READY edge
//  S          out  W  result
//  ZERO       out  1  result is zero (S==0)
//  OVF        out  1  overflow, S saturated
//  UNF        out  1  underflow, S flushed to +0
// BEHAVIOUR
//  Reset: state IDLE, IN_READY=1, OUT_VALID=0, S=0, ZERO=0, OVF=0, UNF=0; RST wins over every other input, any state.
//  States: IDLE -> [ALIGN] -> ADD -> [NORM] -> ROUND -> DONE -> IDLE. IN_READY=1 only in IDLE.
//  IDLE, on accept: register operands; B sign inverted if ADDSUB=1; eff_sub = signA^signB'.
//   swap so L = larger {exp,frac} (tie: L=A); mantissa = {hidden=(exp!=0), frac, G=0, R=0}, sticky=0.
//   d = min(expL-expS, FRAC_W+3); d==0 -> ADD else ALIGN; result sign = sign of L.
//  ALIGN: per cycle small mantissa >>1, shifted-out bit ORed into sticky, d--; d hits 0 -> ADD.
//  ADD: sum = L +/- S on FRAC_W+4 bits (carry,hidden,frac,G,R); subtract includes sticky as borrow-in.
//   sum==0 -> zero result (+0, ZERO=1), go ROUND (no-op).
//   carry set -> >>1 (sticky accumulates), exp+1, go ROUND; hidden=1 -> ROUND; else NORM.
//  NORM: per cycle <<1, exp-1, until hidden=1; n = cycles spent (0..FRAC_W+2).
//  ROUND: RNE, inc = G & (R|sticky|lsb); mantissa overflow -> frac=0, exp+1.
//   exp > 2**EXP_W-1 -> S={sign,all 1s,all 1s}, OVF=1.
//   exp < 1 -> S=0, UNF=1, ZERO=1. Otherwise S packed, flags 0.
//  Exponent arithmetic signed on EXP_W+2 bits; never wraps.
//  DONE: OUT_VALID=1; S/ZERO/OVF/UNF held stable until OUT_READY=1; that edge -> IDLE.
//   No new accept in DONE (no overlap).
//  Latency: OUT_VALID high 2+d+n edges after accept edge; throughput 1 op per 3+d+n cycles with OUT_READY=1.
//  Zero operands: A=0 -> result = B' (B sign inverted if ADDSUB=1); both zero -> +0; exact cancellation -> +0.
//  RST mid-operation: operation discarded, no OUT_VALID, IN_READY=1 on next cycle.
// TESTING (EXP_W=4, FRAC_W=4)
//  1.0+1.0: A=0x070, B=0x070, ADDSUB=0 -> S=0x080, OUT_VALID 2 edges after accept, flags 0.
//  Cancel: A=0x0B5, B=0x0B5, ADDSUB=1 -> S=0x000, ZERO=1; A=0x000, B=0x070, ADDSUB=1 -> S=0x170.
//  Align: A=0x070, B=0x050 -> S=0x074, latency 4; A=0x070, B=0x020 (tie, lsb 0) -> S=0x070 (RNE down).
//  Tie up: A=0x071, B=0x020 -> S=0x072; A=0x0FF+0x0FF -> S=0x0FF, OVF=1; A=0x018, B=0x017, ADDSUB=1 -> S=0, UNF=1.
//  Backpressure: OUT_READY=0 for 5 cycles -> S/flags stable, IN_READY=0; IN_VALID ignored until handshake.
//  Reset: RST=1 during ALIGN (A=0x070, B=0x020) -> next cycle IDLE, OUT_VALID=0, IN_READY=1; no stale result.

Source files
------------

// File: rtl/fpu_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential minifloat add/subtract unit.
// Latency: none, wires only.
// Backpressure: IN_READY gates operand accept, OUT_READY holds a pending result.
interface fpu_addsub_seq_if #(
    parameter int W = 9
);
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ADDSUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] S;
    logic         ZERO;
    logic         OVF;
    logic         UNF;

    // producer of operands and consumer of results
    modport master (
        output IN_VALID, A, B, ADDSUB, OUT_READY,
        input  IN_READY, OUT_VALID, S, ZERO, OVF, UNF
    );

    // the arithmetic unit
    modport slave (
        input  IN_VALID, A, B, ADDSUB, OUT_READY,
        output IN_READY, OUT_VALID, S, ZERO, OVF, UNF
    );
endinterface

// File: rtl/fpu_addsub_seq.sv
// Sequential minifloat add/subtract with bit-serial align/normalise and RNE rounding.
// Latency: OUT_VALID rises 2+d+n edges after accept (d align shifts, n normalise shifts).
// Backpressure: one op in flight; result and flags held in DONE until OUT_READY.
module fpu_addsub_seq #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 4,
    parameter int BIAS   = 2**(EXP_W-1)-1
) (
    input  logic               CLK,
    input  logic               RST,
    fpu_addsub_seq_if.slave    bus
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 3;          // hidden, frac, guard, round
    localparam int SW = MW + 1;              // plus carry
    localparam int EW = EXP_W + 2;           // signed exponent, never wraps
    localparam int DW = $clog2(MW + 1);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_U = EW'((2**EXP_W - 1) - BIAS);
    localparam logic signed [EW-1:0] EMIN_U = EW'(1 - BIAS);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t                 state, state_nx;
    logic                   res_sign, eff_sub, sticky, zero_r;
    logic signed [EW-1:0]   exp_r;
    logic [MW-1:0]          mant_l, mant_s;
    logic [SW-1:0]          sum_r;
    logic [DW-1:0]          d_r;
    logic [W-1:0]           s_r;
    logic                   zero_o, ovf_o, unf_o;

    // operand unpack, magnitude ordering and alignment distance at accept
    logic                   sa, sb, swap;
    logic [EXP_W-1:0]       ea, eb, el, es, ediff;
    logic [FRAC_W-1:0]      fa, fb, fl, fs;
    logic [DW-1:0]          d_in;
    always_comb begin
        sa    = bus.A[W-1];
        ea    = bus.A[W-2 -: EXP_W];
        fa    = (ea != '0) ? bus.A[FRAC_W-1:0] : '0;
        sb    = bus.B[W-1] ^ bus.ADDSUB;
        eb    = bus.B[W-2 -: EXP_W];
        fb    = (eb != '0) ? bus.B[FRAC_W-1:0] : '0;
        swap  = {eb, fb} > {ea, fa};
        el    = swap ? eb : ea;
        fl    = swap ? fb : fa;
        es    = swap ? ea : eb;
        fs    = swap ? fa : fb;
        ediff = el - es;
        d_in  = (int'(ediff) >= MW) ? DW'(MW) : DW'(ediff);
    end

    // mantissa add/subtract; the sticky acts as borrow-in on subtraction
    logic [SW-1:0] sum_c;
    always_comb begin
        if (eff_sub)
            sum_c = {1'b0, mant_l} - {1'b0, mant_s} - SW'(sticky);
        else
            sum_c = {1'b0, mant_l} + {1'b0, mant_s};
    end

    // round-to-nearest-even and range check on the unbiased exponent
    logic                   inc;
    logic [FRAC_W+1:0]      rnd;
    logic signed [EW-1:0]   e_rnd, e_unb;
    always_comb begin
        inc   = sum_r[1] & (sum_r[0] | sticky | sum_r[2]);
        rnd   = {1'b0, sum_r[MW-1:2]} + (FRAC_W+2)'(inc);
        e_rnd = rnd[FRAC_W+1] ? exp_r + EW'(1) : exp_r;
        e_unb = e_rnd - BIAS_E;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.IN_VALID) state_nx = (d_in == '0) ? ADD : ALIGN;
            ALIGN:   if (d_r == DW'(1)) state_nx = ADD;
            ADD:     state_nx = (sum_c == '0 || sum_c[SW-1] || sum_c[SW-2]) ? ROUND : NORM;
            NORM:    if (sum_r[SW-3]) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (bus.OUT_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // handshake and result outputs
    always_comb begin
        bus.IN_READY  = (state == IDLE);
        bus.OUT_VALID = (state == DONE);
        bus.S         = s_r;
        bus.ZERO      = zero_o;
        bus.OVF       = ovf_o;
        bus.UNF       = unf_o;
    end

    // datapath: load, align, add, normalise, round
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_sign <= 1'b0;
            eff_sub  <= 1'b0;
            sticky   <= 1'b0;
            zero_r   <= 1'b0;
            exp_r    <= '0;
            mant_l   <= '0;
            mant_s   <= '0;
            sum_r    <= '0;
            d_r      <= '0;
            s_r      <= '0;
            zero_o   <= 1'b0;
            ovf_o    <= 1'b0;
            unf_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.IN_VALID) begin
                    res_sign <= swap ? sb : sa;
                    eff_sub  <= sa ^ sb;
                    sticky   <= 1'b0;
                    zero_r   <= 1'b0;
                    exp_r    <= {{(EW-EXP_W){1'b0}}, el};
                    mant_l   <= {(el != '0), fl, 2'b00};
                    mant_s   <= {(es != '0), fs, 2'b00};
                    d_r      <= d_in;
                end
                ALIGN: begin
                    mant_s <= mant_s >> 1;
                    sticky <= sticky | mant_s[0];
                    d_r    <= d_r - DW'(1);
                end
                ADD: begin
                    if (sum_c == '0) begin
                        zero_r <= 1'b1;
                        sum_r  <= '0;
                    end else if (sum_c[SW-1]) begin
                        sum_r  <= sum_c >> 1;
                        sticky <= sticky | sum_c[0];
                        exp_r  <= exp_r + EW'(1);
                    end else begin
                        sum_r  <= sum_c;
                    end
                end
                NORM: begin
                    sum_r <= sum_r << 1;
                    exp_r <= exp_r - EW'(1);
                end
                ROUND: begin
                    if (zero_r) begin
                        s_r <= '0; zero_o <= 1'b1; ovf_o <= 1'b0; unf_o <= 1'b0;
                    end else if (e_unb > EMAX_U) begin
                        s_r <= {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
                        zero_o <= 1'b0; ovf_o <= 1'b1; unf_o <= 1'b0;
                    end else if (e_unb < EMIN_U) begin
                        s_r <= '0; zero_o <= 1'b1; ovf_o <= 1'b0; unf_o <= 1'b1;
                    end else begin
                        s_r <= {res_sign, e_rnd[EXP_W-1:0], rnd[FRAC_W-1:0]};
                        zero_o <= 1'b0; ovf_o <= 1'b0; unf_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq (EXP_W=4, FRAC_W=4) with an expected-result queue.
// Each op pushes its expected result and latency; the result is popped when OUT_VALID appears.
// Covers reset, rounding ties, sticky, cancellation, overflow, underflow, backpressure, mid-op reset.
module tb_fpu_addsub_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [8:0] s;
        logic       z;
        logic       o;
        logic       u;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    fpu_addsub_seq_if #(.W(9)) bus();
    fpu_addsub_seq #(.EXP_W(4), .FRAC_W(4)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // one operation; hold>0 keeps OUT_READY low for that many cycles with IN_VALID pulsing garbage
    task automatic run_op(input string tag, input logic [8:0] a, input logic [8:0] b, input logic sub,
                          input logic [8:0] es, input logic ez, input logic eo, input logic eu,
                          input int elat, input int hold);
        exp_t e;
        int   lat;
        sb_q.push_back('{s: es, z: ez, o: eo, u: eu, lat: elat});
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.IN_READY), 32'd1);
        bus.A = a; bus.B = b; bus.ADDSUB = sub; bus.IN_VALID = 1'b1;
        bus.OUT_READY = (hold == 0);
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        lat = 0;
        while (bus.OUT_VALID !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        chk({tag, ".lat"},  32'(lat),      32'(e.lat));
        chk({tag, ".s"},    32'(bus.S),    32'(e.s));
        chk({tag, ".zero"}, 32'(bus.ZERO), 32'(e.z));
        chk({tag, ".ovf"},  32'(bus.OVF),  32'(e.o));
        chk({tag, ".unf"},  32'(bus.UNF),  32'(e.u));
        if (hold > 0) begin
            bus.A = 9'h0B5; bus.B = 9'h012; bus.ADDSUB = 1'b1; bus.IN_VALID = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, ".hold_s"},     32'(bus.S),         32'(e.s));
                chk({tag, ".hold_flags"}, {bus.ZERO, bus.OVF, bus.UNF}, {e.z, e.o, e.u});
                chk({tag, ".hold_valid"}, 32'(bus.OUT_VALID), 32'd1);
                chk({tag, ".hold_ready"}, 32'(bus.IN_READY),  32'd0);
            end
            bus.IN_VALID  = 1'b0;
            bus.OUT_READY = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ".valid_drop"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, ".back_idle"},  32'(bus.IN_READY),  32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        bus.IN_VALID = 1'b1; bus.A = 9'h070; bus.B = 9'h070; bus.ADDSUB = 1'b0; bus.OUT_READY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready",  32'(bus.IN_READY),  32'd1);
        chk("rst.out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst.s",         32'(bus.S),         32'd0);
        chk("rst.flags",     {bus.ZERO, bus.OVF, bus.UNF}, 32'd0);
        bus.IN_VALID = 1'b0;
        rst = 1'b0;

        //      tag          A       B       sub   S       Z     O     U    lat hold
        run_op("one_plus_one", 9'h070, 9'h070, 1'b0, 9'h080, 1'b0, 1'b0, 1'b0, 2, 0);
        run_op("cancel",       9'h0B5, 9'h0B5, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 2, 0);
        run_op("zero_minus",   9'h000, 9'h070, 1'b1, 9'h170, 1'b0, 1'b0, 1'b0, 9, 0);
        run_op("align2",       9'h070, 9'h050, 1'b0, 9'h074, 1'b0, 1'b0, 1'b0, 4, 0);
        run_op("tie_even_dn",  9'h070, 9'h020, 1'b0, 9'h070, 1'b0, 1'b0, 1'b0, 7, 0);
        run_op("tie_odd_up",   9'h071, 9'h020, 1'b0, 9'h072, 1'b0, 1'b0, 1'b0, 7, 0);
        run_op("overflow",     9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0, 2, 0);
        run_op("underflow",    9'h018, 9'h017, 1'b1, 9'h000, 1'b1, 1'b0, 1'b1, 6, 0);
        run_op("both_zero",    9'h000, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 2, 0);
        run_op("two_minus_1",  9'h080, 9'h070, 1'b1, 9'h070, 1'b0, 1'b0, 1'b0, 4, 0);
        run_op("neg_cancel",   9'h170, 9'h070, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 2, 0);
        run_op("sub_negb",     9'h070, 9'h170, 1'b1, 9'h080, 1'b0, 1'b0, 1'b0, 2, 0);
        run_op("sticky_sub",   9'h070, 9'h021, 1'b1, 9'h06F, 1'b0, 1'b0, 1'b0, 8, 0);
        run_op("backpressure", 9'h070, 9'h050, 1'b0, 9'h074, 1'b0, 1'b0, 1'b0, 4, 5);

        // reset while aligning: the operation must vanish
        @(negedge clk);
        bus.A = 9'h070; bus.B = 9'h020; bus.ADDSUB = 1'b0; bus.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("midrst.busy", 32'(bus.IN_READY), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("midrst.in_ready",  32'(bus.IN_READY),  32'd1);
        chk("midrst.s",         32'(bus.S),         32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.OUT_VALID === 1'b1) seen++;
        end
        chk("midrst.no_stale", 32'(seen), 32'd0);
        run_op("after_rst", 9'h070, 9'h050, 1'b0, 9'h074, 1'b0, 1'b0, 1'b0, 4, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
